// File: rtl/fsm_moore_decrypt.sv
// rtl/fsm_moore_decrypt.sv - Moore control FSM sequencing a 4-block AEAD decryption and tag check.
module fsm_moore_decrypt (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic [3:0] round_i,
    input  logic       tag_match_i,
    output logic       input_mode_o,
    output logic       en_reg_state_o,
    output logic       en_xor_begin_data_o,
    output logic       en_xor_begin_key_o,
    output logic       bypass_xor_end_o,
    output logic       mode_xor_key_o,
    output logic       replace_state_o,
    output logic       en_reg_plain_o,
    output logic       en_reg_tag_o,
    output logic       en_cpt_double_o,
    output logic       init_p12_o,
    output logic       init_p8_o,
    output logic       plain_valid_o,
    output logic       end_initialisation_o,
    output logic       end_associate_o,
    output logic       end_plain1_o,
    output logic       end_plain2_o,
    output logic       tag_valid_o,
    output logic       auth_fail_o,
    output logic       end_o
);

    typedef enum logic [4:0] {
        S_IDLE, S_CONF_INIT, S_END_CONF_INIT, S_INIT, S_END_INIT,
        S_IDLE_DA, S_CONF_DA, S_END_CONF_DA, S_DA, S_END_DA,
        S_IDLE_DEC1, S_CONF_DEC1, S_END_CONF_DEC1, S_DEC1, S_END_DEC1,
        S_IDLE_DEC2, S_CONF_DEC2, S_END_CONF_DEC2, S_DEC2, S_END_DEC2,
        S_IDLE_FIN, S_CONF_FIN, S_END_CONF_FIN, S_FIN, S_END_FIN,
        S_TAG_LOAD, S_TAG_CHECK, S_DONE
    } state_t;

    localparam int OB_INPUT_MODE = 19;
    localparam int OB_REG_STATE  = 18;
    localparam int OB_XOR_DATA   = 17;
    localparam int OB_XOR_KEY    = 16;
    localparam int OB_BYPASS     = 15;
    localparam int OB_MODE_KEY   = 14;
    localparam int OB_REPLACE    = 13;
    localparam int OB_REG_PLAIN  = 12;
    localparam int OB_REG_TAG    = 11;
    localparam int OB_CPT        = 10;
    localparam int OB_P12        = 9;
    localparam int OB_P8         = 8;
    localparam int OB_PLAIN_VAL  = 7;
    localparam int OB_END_INIT   = 6;
    localparam int OB_END_ASSOC  = 5;
    localparam int OB_END_PLAIN1 = 4;
    localparam int OB_END_PLAIN2 = 3;
    localparam int OB_TAG_VALID  = 2;
    localparam int OB_AUTH_FAIL  = 1;
    localparam int OB_END        = 0;

    localparam logic [19:0] OUT_DEFAULT = 20'h8C000;

    state_t      r_state;
    logic        r_auth_ok;
    logic [19:0] r_out;
    state_t      w_next;
    logic        w_auth_ok_next;
    logic [19:0] w_out;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:          if (start_i) w_next = S_CONF_INIT;
            S_CONF_INIT:     w_next = S_END_CONF_INIT;
            S_END_CONF_INIT: w_next = S_INIT;
            S_INIT:          if (round_i == 4'ha) w_next = S_END_INIT;
            S_END_INIT:      w_next = S_IDLE_DA;
            S_IDLE_DA:       if (data_valid_i) w_next = S_CONF_DA;
            S_CONF_DA:       w_next = S_END_CONF_DA;
            S_END_CONF_DA:   w_next = S_DA;
            S_DA:            if (round_i == 4'ha) w_next = S_END_DA;
            S_END_DA:        w_next = S_IDLE_DEC1;
            S_IDLE_DEC1:     if (data_valid_i) w_next = S_CONF_DEC1;
            S_CONF_DEC1:     w_next = S_END_CONF_DEC1;
            S_END_CONF_DEC1: w_next = S_DEC1;
            S_DEC1:          if (round_i == 4'ha) w_next = S_END_DEC1;
            S_END_DEC1:      w_next = S_IDLE_DEC2;
            S_IDLE_DEC2:     if (data_valid_i) w_next = S_CONF_DEC2;
            S_CONF_DEC2:     w_next = S_END_CONF_DEC2;
            S_END_CONF_DEC2: w_next = S_DEC2;
            S_DEC2:          if (round_i == 4'ha) w_next = S_END_DEC2;
            S_END_DEC2:      w_next = S_IDLE_FIN;
            S_IDLE_FIN:      if (data_valid_i) w_next = S_CONF_FIN;
            S_CONF_FIN:      w_next = S_END_CONF_FIN;
            S_END_CONF_FIN:  w_next = S_FIN;
            S_FIN:           if (round_i == 4'ha) w_next = S_END_FIN;
            S_END_FIN:       w_next = S_TAG_LOAD;
            S_TAG_LOAD:      w_next = S_TAG_CHECK;
            S_TAG_CHECK:     w_next = S_DONE;
            S_DONE:          if (start_i) w_next = S_CONF_INIT;
            default:         w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_auth_ok_next = r_auth_ok;
        if (r_state == S_TAG_CHECK)
            w_auth_ok_next = tag_match_i;
        else if (r_state == S_DONE && start_i)
            w_auth_ok_next = 1'b0;
    end

    // Outputs are decoded from the next state and registered, so they line up with r_state.
    always_comb begin
        w_out = OUT_DEFAULT;
        case (w_next)
            S_CONF_INIT, S_CONF_FIN: begin
                w_out[OB_CPT] = 1'b1;
                w_out[OB_P12] = 1'b1;
            end
            S_CONF_DA, S_CONF_DEC1, S_CONF_DEC2: begin
                w_out[OB_CPT] = 1'b1;
                w_out[OB_P8]  = 1'b1;
            end
            S_END_CONF_INIT: begin
                w_out[OB_CPT]        = 1'b1;
                w_out[OB_REG_STATE]  = 1'b1;
                w_out[OB_INPUT_MODE] = 1'b0;
            end
            S_END_CONF_DA: begin
                w_out[OB_CPT]       = 1'b1;
                w_out[OB_REG_STATE] = 1'b1;
                w_out[OB_XOR_DATA]  = 1'b1;
            end
            S_END_CONF_DEC1, S_END_CONF_DEC2, S_END_CONF_FIN: begin
                w_out[OB_CPT]       = 1'b1;
                w_out[OB_REG_STATE] = 1'b1;
                w_out[OB_XOR_DATA]  = 1'b1;
                w_out[OB_REPLACE]   = 1'b1;
                w_out[OB_REG_PLAIN] = 1'b1;
                w_out[OB_XOR_KEY]   = (w_next == S_END_CONF_FIN);
            end
            S_INIT, S_DA: begin
                w_out[OB_CPT]       = 1'b1;
                w_out[OB_REG_STATE] = 1'b1;
            end
            S_DEC1, S_DEC2, S_FIN: begin
                w_out[OB_CPT]       = 1'b1;
                w_out[OB_REG_STATE] = 1'b1;
                w_out[OB_PLAIN_VAL] = 1'b1;
            end
            S_END_INIT, S_END_FIN: begin
                w_out[OB_REG_STATE] = 1'b1;
                w_out[OB_BYPASS]    = 1'b0;
            end
            S_END_DA: begin
                w_out[OB_REG_STATE] = 1'b1;
                w_out[OB_BYPASS]    = 1'b0;
                w_out[OB_MODE_KEY]  = 1'b0;
            end
            S_END_DEC1, S_END_DEC2: w_out[OB_REG_STATE] = 1'b1;
            S_IDLE_DA:   w_out[OB_END_INIT]   = 1'b1;
            S_IDLE_DEC1: w_out[OB_END_ASSOC]  = 1'b1;
            S_IDLE_DEC2: w_out[OB_END_PLAIN1] = 1'b1;
            S_IDLE_FIN:  w_out[OB_END_PLAIN2] = 1'b1;
            S_TAG_LOAD:  w_out[OB_REG_TAG]    = 1'b1;
            S_TAG_CHECK: w_out[OB_TAG_VALID]  = 1'b1;
            S_DONE: begin
                w_out[OB_END]       = 1'b1;
                w_out[OB_AUTH_FAIL] = ~w_auth_ok_next;
            end
            default: w_out = OUT_DEFAULT;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state   <= S_IDLE;
            r_auth_ok <= 1'b0;
            r_out     <= OUT_DEFAULT;
        end else begin
            r_state   <= w_next;
            r_auth_ok <= w_auth_ok_next;
            r_out     <= w_out;
        end
    end

    assign input_mode_o         = r_out[OB_INPUT_MODE];
    assign en_reg_state_o       = r_out[OB_REG_STATE];
    assign en_xor_begin_data_o  = r_out[OB_XOR_DATA];
    assign en_xor_begin_key_o   = r_out[OB_XOR_KEY];
    assign bypass_xor_end_o     = r_out[OB_BYPASS];
    assign mode_xor_key_o       = r_out[OB_MODE_KEY];
    assign replace_state_o      = r_out[OB_REPLACE];
    assign en_reg_plain_o       = r_out[OB_REG_PLAIN];
    assign en_reg_tag_o         = r_out[OB_REG_TAG];
    assign en_cpt_double_o      = r_out[OB_CPT];
    assign init_p12_o           = r_out[OB_P12];
    assign init_p8_o            = r_out[OB_P8];
    assign plain_valid_o        = r_out[OB_PLAIN_VAL];
    assign end_initialisation_o = r_out[OB_END_INIT];
    assign end_associate_o      = r_out[OB_END_ASSOC];
    assign end_plain1_o         = r_out[OB_END_PLAIN1];
    assign end_plain2_o         = r_out[OB_END_PLAIN2];
    assign tag_valid_o          = r_out[OB_TAG_VALID];
    assign auth_fail_o          = r_out[OB_AUTH_FAIL];
    assign end_o                = r_out[OB_END];

endmodule

// File: tb/tb_fsm_moore_decrypt.sv
// tb/tb_fsm_moore_decrypt.sv - randomized bench for fsm_moore_decrypt against a phase/position model.
module tb_fsm_moore_decrypt;

    logic       clock_i = 1'b0;
    logic       resetb_i = 1'b0;
    logic       start_i = 1'b0;
    logic       data_valid_i = 1'b0;
    logic       tag_match_i = 1'b0;
    logic [3:0] round_i = 4'h0;

    logic input_mode_o, en_reg_state_o, en_xor_begin_data_o, en_xor_begin_key_o;
    logic bypass_xor_end_o, mode_xor_key_o, replace_state_o, en_reg_plain_o;
    logic en_reg_tag_o, en_cpt_double_o, init_p12_o, init_p8_o, plain_valid_o;
    logic end_initialisation_o, end_associate_o, end_plain1_o, end_plain2_o;
    logic tag_valid_o, auth_fail_o, end_o;

    fsm_moore_decrypt dut (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i),
        .data_valid_i(data_valid_i), .round_i(round_i), .tag_match_i(tag_match_i),
        .input_mode_o(input_mode_o), .en_reg_state_o(en_reg_state_o),
        .en_xor_begin_data_o(en_xor_begin_data_o), .en_xor_begin_key_o(en_xor_begin_key_o),
        .bypass_xor_end_o(bypass_xor_end_o), .mode_xor_key_o(mode_xor_key_o),
        .replace_state_o(replace_state_o), .en_reg_plain_o(en_reg_plain_o),
        .en_reg_tag_o(en_reg_tag_o), .en_cpt_double_o(en_cpt_double_o),
        .init_p12_o(init_p12_o), .init_p8_o(init_p8_o), .plain_valid_o(plain_valid_o),
        .end_initialisation_o(end_initialisation_o), .end_associate_o(end_associate_o),
        .end_plain1_o(end_plain1_o), .end_plain2_o(end_plain2_o),
        .tag_valid_o(tag_valid_o), .auth_fail_o(auth_fail_o), .end_o(end_o)
    );

    always #5 clock_i = ~clock_i;

    wire [19:0] obs = {input_mode_o, en_reg_state_o, en_xor_begin_data_o, en_xor_begin_key_o,
                       bypass_xor_end_o, mode_xor_key_o, replace_state_o, en_reg_plain_o,
                       en_reg_tag_o, en_cpt_double_o, init_p12_o, init_p8_o, plain_valid_o,
                       end_initialisation_o, end_associate_o, end_plain1_o, end_plain2_o,
                       tag_valid_o, auth_fail_o, end_o};

    localparam logic [19:0] DEF = 20'h8C000;

    int checks = 0;
    int errors = 0;
    int m_idx  = 0;
    bit m_ok   = 1'b0;
    int m_cnt  = 0;

    // The 25 pre-tag states are five phases of (wait, conf, end_conf, perm, end).
    function automatic logic [19:0] exp_outs(input int idx, input bit ok);
        int ph, pos;
        bit inph;
        ph = idx / 5;
        pos = idx % 5;
        inph = (idx < 25);
        exp_outs = '0;
        exp_outs[19] = (idx != 2);
        exp_outs[18] = inph && pos >= 2;
        exp_outs[17] = inph && pos == 2 && ph >= 1;
        exp_outs[16] = (idx == 22);
        exp_outs[15] = !(inph && pos == 4 && (ph == 0 || ph == 1 || ph == 4));
        exp_outs[14] = (idx != 9);
        exp_outs[13] = inph && pos == 2 && ph >= 2;
        exp_outs[12] = inph && pos == 2 && ph >= 2;
        exp_outs[11] = (idx == 25);
        exp_outs[10] = inph && pos >= 1 && pos <= 3;
        exp_outs[9]  = inph && pos == 1 && (ph == 0 || ph == 4);
        exp_outs[8]  = inph && pos == 1 && ph >= 1 && ph <= 3;
        exp_outs[7]  = inph && pos == 3 && ph >= 2;
        exp_outs[6]  = (idx == 5);
        exp_outs[5]  = (idx == 10);
        exp_outs[4]  = (idx == 15);
        exp_outs[3]  = (idx == 20);
        exp_outs[2]  = (idx == 26);
        exp_outs[1]  = (idx == 27) && !ok;
        exp_outs[0]  = (idx == 27);
    endfunction

    function automatic bit pick_s(input int idx);
        if (idx == 0 || idx == 27) return ($urandom % 3) == 0;
        return 1'($urandom % 2);
    endfunction

    function automatic bit pick_dv(input int idx);
        if (idx < 25 && idx % 5 == 0 && idx != 0) return ($urandom % 3) == 0;
        return 1'($urandom % 2);
    endfunction

    // Drives one cycle from a negedge and advances the model across the next posedge.
    task automatic step(input bit s, input bit dv, input bit tm);
        logic [19:0] e;
        int nidx, pos, ph;
        bit nok;
        start_i = s;
        data_valid_i = dv;
        tag_match_i = tm;
        round_i = m_cnt[3:0];
        e = exp_outs(m_idx, m_ok);
        nidx = m_idx;
        nok = m_ok;
        pos = m_idx % 5;
        ph = m_idx / 5;
        if (m_idx < 25) begin
            case (pos)
                0: if (ph == 0 ? s : dv) nidx = m_idx + 1;
                3: if (m_cnt == 10) nidx = m_idx + 1;
                default: nidx = m_idx + 1;
            endcase
        end else if (m_idx == 25 || m_idx == 26) begin
            nidx = m_idx + 1;
        end else if (s) begin
            nidx = 1;
        end
        if (m_idx == 26) nok = tm;
        else if (m_idx == 27 && s) nok = 1'b0;
        if (e[9]) m_cnt = 0;
        else if (e[8]) m_cnt = 4;
        else if (e[10]) m_cnt = m_cnt + 1;
        @(posedge clock_i);
        m_idx = nidx;
        m_ok = nok;
        @(negedge clock_i);
    endtask

    task automatic test_reset();
        resetb_i = 1'b0;
        @(negedge clock_i);
        checks++;
        if (obs !== DEF) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, DEF);
        end
        resetb_i = 1'b1;
        m_idx = 0; m_ok = 1'b0; m_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs !== exp_outs(m_idx, m_ok)) begin
                errors++;
                $display("FAIL idle_hold cycle %0d: got %h expected %h", i, obs, exp_outs(m_idx, m_ok));
            end
            step(1'b0, 1'($urandom % 2), 1'($urandom % 2));
        end
    endtask

    task automatic test_full_run(input bit tm);
        bit left;
        int budget;
        left = (m_idx != 27);
        budget = 0;
        while (!(m_idx == 27 && left) && budget < 400) begin
            checks++;
            if (obs !== exp_outs(m_idx, m_ok)) begin
                errors++;
                $display("FAIL run_outputs idx %0d round %0d: got %h expected %h", m_idx, m_cnt, obs, exp_outs(m_idx, m_ok));
            end
            if (m_idx == 12) begin
                checks++;
                if ({en_xor_begin_data_o, en_xor_begin_key_o, replace_state_o, en_reg_plain_o} !== 4'b1011) begin
                    errors++;
                    $display("FAIL end_conf_dec1_bits: got %b expected 1011",
                             {en_xor_begin_data_o, en_xor_begin_key_o, replace_state_o, en_reg_plain_o});
                end
            end
            if (m_idx == 22) begin
                checks++;
                if ({en_xor_begin_data_o, en_xor_begin_key_o, replace_state_o, en_reg_plain_o} !== 4'b1111) begin
                    errors++;
                    $display("FAIL end_conf_fin_bits: got %b expected 1111",
                             {en_xor_begin_data_o, en_xor_begin_key_o, replace_state_o, en_reg_plain_o});
                end
            end
            if (m_idx == 19) begin
                checks++;
                if (bypass_xor_end_o !== 1'b1) begin
                    errors++;
                    $display("FAIL end_dec2_bypass: got %b expected 1", bypass_xor_end_o);
                end
            end
            step((m_idx >= 5 && m_idx <= 9) ? 1'b1 : pick_s(m_idx), pick_dv(m_idx),
                 (m_idx == 26) ? tm : 1'($urandom % 2));
            if (m_idx != 27) left = 1'b1;
            budget++;
        end
        checks++;
        if (budget >= 400) begin
            errors++;
            $display("FAIL run_timeout: got %0d cycles expected < 400", budget);
        end
        checks++;
        if ({end_o, auth_fail_o} !== {1'b1, ~tm}) begin
            errors++;
            $display("FAIL run_result: got end=%b auth_fail=%b expected end=1 auth_fail=%b", end_o, auth_fail_o, ~tm);
        end
    endtask

    task automatic test_fail_restart();
        test_full_run(1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if ({init_p12_o, en_cpt_double_o, auth_fail_o, end_o} !== 4'b1100) begin
            errors++;
            $display("FAIL restart_conf_init: got %b expected 1100", {init_p12_o, en_cpt_double_o, auth_fail_o, end_o});
        end
        test_full_run(1'b1);
    endtask

    task automatic test_wait_dec1();
        int budget;
        budget = 0;
        while (m_idx != 10 && budget < 200) begin
            checks++;
            if (obs !== exp_outs(m_idx, m_ok)) begin
                errors++;
                $display("FAIL to_dec1_outputs idx %0d: got %h expected %h", m_idx, obs, exp_outs(m_idx, m_ok));
            end
            step(1'b1, pick_dv(m_idx), 1'b0);
            budget++;
        end
        checks++;
        if (budget >= 200) begin
            errors++;
            $display("FAIL to_dec1_timeout: got %0d cycles expected < 200", budget);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({end_associate_o, en_reg_state_o} !== 2'b10) begin
                errors++;
                $display("FAIL dec1_wait cycle %0d: got end_assoc=%b en_reg_state=%b expected 1 0", i, end_associate_o, en_reg_state_o);
            end
            step(1'($urandom % 2), 1'b0, 1'($urandom % 2));
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if ({init_p8_o, en_cpt_double_o, end_associate_o} !== 3'b110) begin
            errors++;
            $display("FAIL conf_dec1_entry: got %b expected 110", {init_p8_o, en_cpt_double_o, end_associate_o});
        end
        test_full_run(1'b1);
    endtask

    task automatic test_async_reset(input int target, input int rnd);
        int budget;
        budget = 0;
        while (!(m_idx == target && (rnd < 0 || m_cnt == rnd)) && budget < 300) begin
            step(pick_s(m_idx), pick_dv(m_idx), 1'($urandom % 2));
            budget++;
        end
        checks++;
        if (budget >= 300) begin
            errors++;
            $display("FAIL reset_target_timeout: got %0d cycles expected < 300", budget);
        end
        round_i = m_cnt[3:0];
        #2 resetb_i = 1'b0;
        #1;
        checks++;
        if (obs !== DEF) begin
            errors++;
            $display("FAIL async_reset idx %0d: got %h expected %h", target, obs, DEF);
        end
        m_idx = 0; m_ok = 1'b0; m_cnt = 0;
        @(negedge clock_i);
        resetb_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            checks++;
            if (obs !== DEF) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d: got %h expected %h", i, obs, DEF);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_outs(1, 1'b0)) begin
            errors++;
            $display("FAIL post_reset_start: got %h expected %h", obs, exp_outs(1, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            test_full_run(1'($urandom % 2));
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs !== exp_outs(m_idx, m_ok)) begin
                    errors++;
                    $display("FAIL done_hold run %0d: got %h expected %h", r, obs, exp_outs(m_idx, m_ok));
                end
                step(1'b0, 1'($urandom % 2), 1'($urandom % 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_run(1'b1);
        test_fail_restart();
        test_wait_dec1();
        test_async_reset(18, 7);
        test_async_reset(26, -1);
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_moore_decrypt.md
FSM_MOORE_DECRYPT -- requirements
Module: fsm_moore_decrypt

Interface
REQ-001 SHALL have clock_i, input, 1: single system clock, all state updates on rising edge.
REQ-002 SHALL have resetb_i, input, 1: asynchronous reset, active low; the block has one clock, and reset is asynchronous and active-low.
REQ-003 SHALL have start_i, input, 1: begins a decryption when high in idle or done.
REQ-004 SHALL have data_valid_i, input, 1: next block (AD, C1, C2, C3) is present on the datapath.
REQ-005 SHALL have round_i, input, 4: external round counter value.
REQ-006 SHALL have tag_match_i, input, 1: datapath comparator result, computed tag equals received tag.
REQ-007 SHALL have these 1-bit outputs, each with its reset/default value:
- input_mode_o (1)
- en_reg_state_o (0)
- en_xor_begin_data_o (0)
- en_xor_begin_key_o (0)
- bypass_xor_end_o (1)
- mode_xor_key_o (1)
- replace_state_o (0): x0 <- ciphertext instead of x0 ^ data
- en_reg_plain_o (0)
- en_reg_tag_o (0)
- en_cpt_double_o (0)
- init_p12_o (0)
- init_p8_o (0)
- plain_valid_o (0)
- end_initialisation_o (0)
- end_associate_o (0)
- end_plain1_o (0)
- end_plain2_o (0)
- tag_valid_o (0)
- auth_fail_o (0)
- end_o (0)

Function
REQ-008 SHALL be a Moore FSM; all outputs decode from current state only, except auth_fail_o, which uses state plus flop auth_ok_q.
REQ-009 SHALL use these states, in order:
- idle, conf_init, end_conf_init, init, end_init
- idle_da, conf_da, end_conf_da, da, end_da
- idle_dec1, conf_dec1, end_conf_dec1, dec1, end_dec1
- idle_dec2, conf_dec2, end_conf_dec2, dec2, end_dec2
- idle_fin, conf_fin, end_conf_fin, fin, end_fin
- tag_load, tag_check, done
REQ-010 SHALL make these transitions:
- idle -> conf_init when start_i=1.
- idle_da/idle_dec1/idle_dec2/idle_fin -> their conf_* state when data_valid_i=1; otherwise hold.
- conf_x -> end_conf_x -> x (unconditional).
- x -> end_x when round_i=4'ha; otherwise hold.
- end_init->idle_da, end_da->idle_dec1, end_dec1->idle_dec2, end_dec2->idle_fin.
- end_fin->tag_load->tag_check->done.
- done -> conf_init when start_i=1; otherwise hold.
- Any illegal state -> idle.
REQ-011 SHALL assert en_cpt_double_o in every conf_*, end_conf_* and permutation state (init, da, dec1, dec2, fin), and deassert it elsewhere.
REQ-012 SHALL assert init_p12_o in conf_init and conf_fin, and init_p8_o in conf_da, conf_dec1 and conf_dec2 (counter loads 0 or 4).
REQ-013 SHALL assert en_reg_state_o in every end_conf_*, permutation and end_* state.
REQ-014 SHALL drive input_mode_o=0 only in end_conf_init (load initial state).
REQ-015 SHALL assert en_xor_begin_data_o in end_conf_da.
REQ-016 SHALL assert en_xor_begin_data_o, replace_state_o and en_reg_plain_o in end_conf_dec1, end_conf_dec2 and end_conf_fin; SHALL additionally assert en_xor_begin_key_o in end_conf_fin.
REQ-017 SHALL assert plain_valid_o in dec1, dec2 and fin.
REQ-018 SHALL drive bypass_xor_end_o=0 in end_init (mode_xor_key_o=1), end_da (mode_xor_key_o=0, domain bit) and end_fin (mode_xor_key_o=1); end_dec1 and end_dec2 SHALL keep the bypass.
REQ-019 SHALL assert phase flags for one state each: end_initialisation_o in idle_da, end_associate_o in idle_dec1, end_plain1_o in idle_dec2, end_plain2_o in idle_fin.
REQ-020 SHALL assert en_reg_tag_o in tag_load, and tag_valid_o in tag_check.
REQ-021 SHALL load auth_ok_q <= tag_match_i on the clock edge leaving tag_check, and SHALL clear auth_ok_q when leaving done.
REQ-022 SHALL assert end_o in done; auth_fail_o SHALL equal (state==done) & ~auth_ok_q.
REQ-023 SHALL take the decision path when start_i or data_valid_i is asserted while the FSM is not waiting: the input is ignored and causes no state change.

Reset
REQ-024 SHALL on resetb_i=0 immediately force state=idle and auth_ok_q=0, with all outputs at their REQ-007 defaults; this holds mid-operation and within tag_check.
REQ-025 SHALL, after reset release, stay in idle until start_i=1 is sampled.

Verification
REQ-026 Full run with a behavioural counter (load 0/4 on init_p12/init_p8, +1 on en_cpt_double), data_valid_i pulsed in each idle_* state, tag_match_i=1 -> visits all 28 states in order, with the 10 permutation cycles (rounds 1-10) for init/fin; 6 cycles (rounds 5-10) for da/dec1/dec2; end_o=1, auth_fail_o=0.
REQ-027 Same run with tag_match_i=0 in tag_check -> end_o=1, auth_fail_o=1; then start_i=1 -> conf_init next cycle, with auth_fail_o=0.
REQ-028 data_valid_i held low 20 cycles in idle_dec1 -> end_associate_o stays 1 and en_reg_state_o=0 throughout; a pulse then -> conf_dec1.
REQ-029 resetb_i=0 asserted asynchronously mid-dec2 (round_i=7) -> outputs at defaults before the next edge; state=idle.
REQ-030 end_conf_dec1 -> en_xor_begin_data_o=replace_state_o=en_reg_plain_o=1 and en_xor_begin_key_o=0; end_conf_fin -> all four =1.
REQ-031 start_i=1 held during the da phase -> no effect; end_dec2 -> bypass_xor_end_o=1.
